// File: rtl/pll_lock_supervisor.sv
// Purpose : PLL reset sequencing, lock qualification, staggered domain reset release, loss/timeout retry supervision.
// Latency : extlock -> lock_s is 2 cycles; every output is a flop updated from the next-state decode.
// Backpressure: none; free-running on refclk, sw_relock is a single-cycle request that is always accepted.
module pll_lock_supervisor #(
  parameter int N_DOMAINS    = 4,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                 refclk,
  input  logic                 reset,
  input  logic                 extlock,
  input  logic                 sw_relock,
  output logic                 pll_reset,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 locked,
  output logic                 fail,
  output logic [3:0]           retry_cnt,
  output logic [7:0]           loss_cnt,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  // One phase timer is shared by the hold, timeout and stagger phases; size it for the longest.
  localparam int TW = $clog2(LOCK_TIMEOUT + RST_HOLD + N_DOMAINS * STAGGER + 2);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  localparam logic [TW-1:0] HOLD_LAST = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] REL_LAST  = TW'((N_DOMAINS - 1) * STAGGER);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  state_t                 cur, nxt;
  logic                   sync1, lock_s;
  logic [TW-1:0]          tmr, tmr_nxt;
  logic [SW-1:0]          stab, stab_nxt;
  logic [3:0]             retry_nxt;
  logic [7:0]             loss_nxt;
  logic [N_DOMAINS-1:0]   drst_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge refclk) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= extlock;
      lock_s <= sync1;
    end
  end

  // Next-state, counter and output decode; sw_relock pre-empts every state transition.
  always_comb begin
    nxt       = cur;
    tmr_nxt   = tmr + 1'b1;
    stab_nxt  = stab;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    drst_nxt  = '1;

    if (sw_relock) begin
      nxt       = S_RESET_PLL;
      tmr_nxt   = '0;
      stab_nxt  = '0;
      retry_nxt = 4'd0;
    end else begin
      case (cur)
        S_RESET_PLL: begin
          if (tmr == HOLD_LAST) begin
            nxt      = S_WAIT_LOCK;
            tmr_nxt  = '0;
            stab_nxt = '0;
          end
        end
        S_WAIT_LOCK: begin
          // Stability is tested before timeout so a simultaneous finish releases.
          if (lock_s && (stab == STAB_LAST)) begin
            nxt     = S_RELEASE;
            tmr_nxt = '0;
          end else if (tmr == TO_LAST) begin
            retry_nxt = retry_cnt + 4'd1;
            nxt       = (retry_nxt == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
            tmr_nxt   = '0;
          end else begin
            stab_nxt = lock_s ? (stab + 1'b1) : '0;
          end
        end
        S_RELEASE: begin
          if (!lock_s) begin
            nxt      = S_RESET_PLL;
            tmr_nxt  = '0;
            loss_nxt = (loss_cnt == 8'hFF) ? loss_cnt : (loss_cnt + 8'd1);
          end else if (tmr == REL_LAST) begin
            nxt       = S_RUN;
            tmr_nxt   = '0;
            retry_nxt = 4'd0;
          end
        end
        S_RUN: begin
          tmr_nxt = tmr;
          if (!lock_s) begin
            nxt      = S_RESET_PLL;
            tmr_nxt  = '0;
            loss_nxt = (loss_cnt == 8'hFF) ? loss_cnt : (loss_cnt + 8'd1);
          end
        end
        S_FAIL: begin
          tmr_nxt = tmr;
        end
        default: begin
          nxt     = S_RESET_PLL;
          tmr_nxt = '0;
        end
      endcase
    end

    // Domain k leaves reset once the release phase has run k*STAGGER cycles.
    if (nxt == S_RUN) begin
      drst_nxt = '0;
    end else if (nxt == S_RELEASE) begin
      for (int k = 0; k < N_DOMAINS; k++) begin
        drst_nxt[k] = (int'(tmr_nxt) < k * STAGGER);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (reset) begin
      cur        <= S_RESET_PLL;
      tmr        <= '0;
      stab       <= '0;
      retry_cnt  <= 4'd0;
      loss_cnt   <= 8'd0;
      pll_reset  <= 1'b1;
      domain_rst <= '1;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      cur        <= nxt;
      tmr        <= tmr_nxt;
      stab       <= stab_nxt;
      retry_cnt  <= retry_nxt;
      loss_cnt   <= loss_nxt;
      pll_reset  <= (nxt == S_RESET_PLL) || (nxt == S_FAIL);
      domain_rst <= drst_nxt;
      locked     <= (nxt == S_RUN);
      fail       <= (nxt == S_FAIL);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a default-parameter instance for the headline timing figures
// and a small-parameter instance (LOCK_TIMEOUT = LOCK_STABLE+2) for saturation, tie and random runs.
// Outputs are sampled 1 ns after each rising edge; inputs are changed at the same point.
module tb_pll_lock_supervisor;

  localparam int F_N = 4, F_HOLD = 3, F_LS = 10, F_LT = 12, F_STAG = 2, F_MAXR = 2;

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  int checks = 0;
  int passes = 0;

  // default-parameter DUT
  logic       d_reset = 1'b1, d_extlock = 1'b0, d_sw_relock = 1'b0;
  logic       d_pll_reset, d_locked, d_fail;
  logic [3:0] d_domain_rst, d_retry_cnt;
  logic [7:0] d_loss_cnt;
  logic [2:0] d_state;

  // small-parameter DUT
  logic       f_reset = 1'b1, f_extlock = 1'b0, f_sw_relock = 1'b0;
  logic       f_pll_reset, f_locked, f_fail;
  logic [3:0] f_domain_rst, f_retry_cnt;
  logic [7:0] f_loss_cnt;
  logic [2:0] f_state;

  pll_lock_supervisor u_dut (
    .refclk(refclk), .reset(d_reset), .extlock(d_extlock), .sw_relock(d_sw_relock),
    .pll_reset(d_pll_reset), .domain_rst(d_domain_rst), .locked(d_locked), .fail(d_fail),
    .retry_cnt(d_retry_cnt), .loss_cnt(d_loss_cnt), .state(d_state)
  );

  pll_lock_supervisor #(
    .N_DOMAINS(F_N), .RST_HOLD(F_HOLD), .LOCK_STABLE(F_LS), .LOCK_TIMEOUT(F_LT),
    .STAGGER(F_STAG), .MAX_RETRIES(F_MAXR)
  ) u_fast (
    .refclk(refclk), .reset(f_reset), .extlock(f_extlock), .sw_relock(f_sw_relock),
    .pll_reset(f_pll_reset), .domain_rst(f_domain_rst), .locked(f_locked), .fail(f_fail),
    .retry_cnt(f_retry_cnt), .loss_cnt(f_loss_cnt), .state(f_state)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // ---------------- reference model for the small instance ----------------
  // phase: 0 reset_pll, 1 wait, 2 release, 3 run, 4 fail; m_t = cycles spent in the phase.
  int m_phase, m_t, m_stable, m_retry, m_loss;
  bit m_s1, m_s2;

  task automatic model_step(input bit r, input bit el, input bit sw);
    bit ls;
    ls = m_s2;
    if (r) begin
      m_phase = 0; m_t = 0; m_stable = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = el;
    if (sw) begin
      m_phase = 0; m_t = 0; m_stable = 0; m_retry = 0;
      return;
    end
    case (m_phase)
      0: begin
        m_t++;
        if (m_t == F_HOLD) begin m_phase = 1; m_t = 0; m_stable = 0; end
      end
      1: begin
        m_t++;
        m_stable = ls ? m_stable + 1 : 0;
        if (m_stable == F_LS) begin m_phase = 2; m_t = 0; end
        else if (m_t == F_LT) begin
          m_retry++;
          m_phase = (m_retry == F_MAXR) ? 4 : 0;
          m_t = 0;
        end
      end
      2, 3: begin
        if (!ls) begin
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          m_phase = 0; m_t = 0;
        end else if (m_phase == 2) begin
          m_t++;
          if (m_t > (F_N - 1) * F_STAG) begin m_phase = 3; m_retry = 0; end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [3:0] model_drst();
    logic [3:0] v;
    v = 4'hF;
    if (m_phase == 3) v = 4'h0;
    else if (m_phase == 2)
      for (int k = 0; k < F_N; k++) v[k] = (m_t < k * F_STAG);
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    d_reset = 1; f_reset = 1; d_sw_relock = 0; f_sw_relock = 0;
    tick(); tick();
    checks++;
    if ({d_state, d_pll_reset, d_domain_rst, d_locked, d_fail, d_retry_cnt, d_loss_cnt} !==
        {3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      $display("FAIL reset_default: got st=%0d pr=%b dr=%b lk=%b fl=%b rc=%0d lc=%0d required st=0 pr=1 dr=1111 lk=0 fl=0 rc=0 lc=0",
               d_state, d_pll_reset, d_domain_rst, d_locked, d_fail, d_retry_cnt, d_loss_cnt);
    end else passes++;
    checks++;
    if ({f_state, f_pll_reset, f_domain_rst, f_locked, f_fail, f_retry_cnt, f_loss_cnt} !==
        {3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      $display("FAIL reset_fast: got st=%0d pr=%b dr=%b lk=%b fl=%b rc=%0d lc=%0d required reset values",
               f_state, f_pll_reset, f_domain_rst, f_locked, f_fail, f_retry_cnt, f_loss_cnt);
    end else passes++;
  endtask

  task automatic test_power_up();
    int c;
    c = 0;
    d_extlock = 1; d_reset = 1; tick(); d_reset = 0;
    while (d_pll_reset === 1'b1 && c < 100) begin tick(); c++; end
    checks++;
    if (c != 16) $display("FAIL pwr_pll_reset_fall: cycle %0d required 16", c); else passes++;
    while (d_domain_rst[0] === 1'b1 && c < 1000) begin tick(); c++; end
    checks++;
    if (c != 272) $display("FAIL pwr_drst0_fall: cycle %0d required 272", c); else passes++;
    checks++;
    if (d_domain_rst !== 4'b1110) $display("FAIL pwr_drst_first: got %b required 1110", d_domain_rst); else passes++;
    while (d_domain_rst[3] === 1'b1 && c < 1000) begin tick(); c++; end
    checks++;
    if (c != 296 || d_locked !== 1'b0)
      $display("FAIL pwr_drst3_fall: cycle %0d locked=%b required 296 locked=0", c, d_locked);
    else passes++;
    tick(); c++;
    checks++;
    if ({d_locked, d_state, d_loss_cnt, d_domain_rst} !== {1'b1, 3'd3, 8'd0, 4'h0})
      $display("FAIL pwr_run: got lk=%b st=%0d lc=%0d dr=%b required lk=1 st=3 lc=0 dr=0000",
               d_locked, d_state, d_loss_cnt, d_domain_rst);
    else passes++;
  endtask

  task automatic test_timeout_fail();
    int c, lows, rises;
    logic prev;
    c = 0; lows = 0; rises = 0;
    d_extlock = 0; d_reset = 1; tick(); d_reset = 0;
    prev = d_pll_reset;
    while (d_fail !== 1'b1 && c < 20000) begin
      tick(); c++;
      if (prev === 1'b0 && d_pll_reset === 1'b1) rises++;
      if (d_pll_reset === 1'b0) lows++;
      prev = d_pll_reset;
    end
    checks++;
    if (c != 12336) $display("FAIL to_fail_cycle: cycle %0d required 12336", c); else passes++;
    checks++;
    if (lows != 3 * 4096 || rises != 3)
      $display("FAIL to_pulses: low cycles %0d rises %0d required 12288 and 3", lows, rises);
    else passes++;
    repeat (20) tick();
    checks++;
    if ({d_state, d_fail, d_retry_cnt, d_pll_reset, d_domain_rst, d_locked} !== {3'd4, 1'b1, 4'd3, 1'b1, 4'hF, 1'b0})
      $display("FAIL to_fail_hold: got st=%0d fl=%b rc=%0d pr=%b dr=%b lk=%b required st=4 fl=1 rc=3 pr=1 dr=1111 lk=0",
               d_state, d_fail, d_retry_cnt, d_pll_reset, d_domain_rst, d_locked);
    else passes++;
    d_sw_relock = 1; tick(); d_sw_relock = 0;
    checks++;
    if ({d_state, d_fail, d_retry_cnt, d_pll_reset} !== {3'd0, 1'b0, 4'd0, 1'b1})
      $display("FAIL to_relock: got st=%0d fl=%b rc=%0d pr=%b required st=0 fl=0 rc=0 pr=1",
               d_state, d_fail, d_retry_cnt, d_pll_reset);
    else passes++;
    repeat (15) tick();
    checks++;
    if (d_pll_reset !== 1'b1) $display("FAIL to_relock_hold15: got pr=%b required 1", d_pll_reset); else passes++;
    tick();
    checks++;
    if (d_pll_reset !== 1'b0 || d_state !== 3'd1)
      $display("FAIL to_relock_hold16: got pr=%b st=%0d required pr=0 st=1", d_pll_reset, d_state);
    else passes++;
  endtask

  task automatic test_wait_glitch();
    int c;
    c = 0;
    d_extlock = 0; d_reset = 1; tick(); d_reset = 0;
    while (d_pll_reset === 1'b1 && c < 100) begin tick(); c++; end
    d_extlock = 1; repeat (200) tick();
    d_extlock = 0; repeat (3) tick();
    d_extlock = 1;
    c = 0;
    while (d_domain_rst[0] === 1'b1 && c < 1000) begin tick(); c++; end
    checks++;
    if (c != 258) $display("FAIL glitch_release: %0d cycles after final rise, required 258", c); else passes++;
  endtask

  task automatic test_run_loss();
    int c;
    c = 0;
    while (d_locked !== 1'b1 && c < 1000) begin tick(); c++; end
    d_extlock = 0; tick(); d_extlock = 1; tick();
    checks++;
    if (d_locked !== 1'b1 || d_domain_rst !== 4'h0)
      $display("FAIL loss_early: got lk=%b dr=%b required lk=1 dr=0000 two cycles after drop", d_locked, d_domain_rst);
    else passes++;
    tick();
    checks++;
    if ({d_domain_rst, d_locked, d_loss_cnt, d_state, d_pll_reset} !== {4'hF, 1'b0, 8'd1, 3'd0, 1'b1})
      $display("FAIL loss_react: got dr=%b lk=%b lc=%0d st=%0d pr=%b required dr=1111 lk=0 lc=1 st=0 pr=1",
               d_domain_rst, d_locked, d_loss_cnt, d_state, d_pll_reset);
    else passes++;
    c = 0;
    while (d_locked !== 1'b1 && c < 1000) begin tick(); c++; end
    checks++;
    if (c != 297) $display("FAIL loss_relock: locked after %0d cycles required 297", c); else passes++;
  endtask

  task automatic test_tie();
    int c;
    f_extlock = 0; f_reset = 1; tick(); f_reset = 0;
    c = 0;
    while (f_state !== 3'd1 && c < 50) begin tick(); c++; end
    f_extlock = 1; repeat (F_LT) tick();
    checks++;
    if ({f_state, f_retry_cnt, f_domain_rst[0]} !== {3'd2, 4'd0, 1'b0})
      $display("FAIL tie_stable_wins: got st=%0d rc=%0d dr0=%b required st=2 rc=0 dr0=0", f_state, f_retry_cnt, f_domain_rst[0]);
    else passes++;
    f_extlock = 0; f_reset = 1; tick(); f_reset = 0;
    c = 0;
    while (f_state !== 3'd1 && c < 50) begin tick(); c++; end
    tick(); f_extlock = 1; repeat (F_LT - 1) tick();
    checks++;
    if ({f_state, f_retry_cnt, f_pll_reset} !== {3'd0, 4'd1, 1'b1})
      $display("FAIL tie_near_miss: got st=%0d rc=%0d pr=%b required st=0 rc=1 pr=1", f_state, f_retry_cnt, f_pll_reset);
    else passes++;
  endtask

  task automatic test_relock_vs_loss();
    int c;
    f_extlock = 1; f_reset = 1; tick(); f_reset = 0;
    c = 0;
    while (f_locked !== 1'b1 && c < 200) begin tick(); c++; end
    f_extlock = 0; tick(); f_extlock = 1; tick(); tick();
    c = 0;
    while (f_locked !== 1'b1 && c < 200) begin tick(); c++; end
    f_extlock = 0; tick(); f_extlock = 1; tick();
    f_sw_relock = 1; tick(); f_sw_relock = 0;
    checks++;
    if ({f_loss_cnt, f_state, f_retry_cnt, f_domain_rst, f_locked} !== {8'd1, 3'd0, 4'd0, 4'hF, 1'b0})
      $display("FAIL relock_vs_loss: got lc=%0d st=%0d rc=%0d dr=%b lk=%b required lc=1 st=0 rc=0 dr=1111 lk=0",
               f_loss_cnt, f_state, f_retry_cnt, f_domain_rst, f_locked);
    else passes++;
  endtask

  task automatic test_loss_saturation();
    int c, expv;
    f_extlock = 1; f_reset = 1; tick(); f_reset = 0;
    for (int i = 1; i <= 300; i++) begin
      c = 0;
      while (f_locked !== 1'b1 && c < 200) begin tick(); c++; end
      if (c >= 200) begin
        checks++;
        $display("FAIL sat_timeout: no lock within 200 cycles at loss %0d, locked=%b required 1", i, f_locked);
        break;
      end
      f_extlock = 0; tick(); f_extlock = 1; tick(); tick();
      expv = (i > 255) ? 255 : i;
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
        checks++;
        if (f_loss_cnt !== 8'(expv)) $display("FAIL sat_loss_%0d: got %0d required %0d", i, f_loss_cnt, expv);
        else passes++;
      end
    end
  endtask

  task automatic test_relock_with_reset();
    int c;
    c = 0;
    while (f_locked !== 1'b1 && c < 200) begin tick(); c++; end
    f_reset = 1; f_sw_relock = 1; tick(); f_reset = 0; f_sw_relock = 0;
    checks++;
    if ({f_state, f_pll_reset, f_domain_rst, f_locked, f_fail, f_retry_cnt, f_loss_cnt} !==
        {3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0})
      $display("FAIL reset_with_relock: got st=%0d pr=%b dr=%b lk=%b fl=%b rc=%0d lc=%0d required reset values",
               f_state, f_pll_reset, f_domain_rst, f_locked, f_fail, f_retry_cnt, f_loss_cnt);
    else passes++;
  endtask

  task automatic test_random();
    int lowrun, r;
    bit el, sw, rs;
    logic [2:0] e_st;
    logic [3:0] e_dr, e_rc;
    logic [7:0] e_lc;
    lowrun = 0;
    f_reset = 1; f_sw_relock = 0; f_extlock = 0;
    model_step(1, 0, 0);
    tick();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (lowrun > 0) begin el = 0; lowrun--; end
      else begin
        el = 1;
        r = int'($urandom_range(0, 99));
        if (r < 3) lowrun = int'($urandom_range(1, 4));
        else if (r == 3) lowrun = int'($urandom_range(10, 40));
      end
      sw = ($urandom_range(0, 149) == 0);
      rs = ($urandom_range(0, 799) == 0);
      f_extlock = el; f_sw_relock = sw; f_reset = rs;
      model_step(rs, el, sw);
      tick();
      e_st = 3'(m_phase); e_dr = model_drst(); e_rc = 4'(m_retry); e_lc = 8'(m_loss);
      checks++;
      if ({f_state, f_pll_reset, f_domain_rst, f_locked, f_fail, f_retry_cnt, f_loss_cnt} !==
          {e_st, (m_phase == 0 || m_phase == 4), e_dr, (m_phase == 3), (m_phase == 4), e_rc, e_lc})
        $display("FAIL random_cyc%0d: got st=%0d pr=%b dr=%b lk=%b fl=%b rc=%0d lc=%0d required st=%0d dr=%b rc=%0d lc=%0d",
                 cyc, f_state, f_pll_reset, f_domain_rst, f_locked, f_fail, f_retry_cnt, f_loss_cnt,
                 e_st, e_dr, e_rc, e_lc);
      else passes++;
    end
    f_reset = 0; f_sw_relock = 0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_timeout_fail();
    test_wait_glitch();
    test_run_loss();
    test_tie();
    test_relock_vs_loss();
    test_loss_saturation();
    test_relock_with_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Clock-manager companion for the PLL wrapper. Runs on the PLL reference clock.
- Drives the PLL reset and qualifies its raw lock flag through synchronisation and stability filtering.
- Releases per-domain synchronous resets in a staggered order, and supervises lock-loss and lock-timeout with bounded automatic retries.
- Sits between the PLL instance and the acquisition, sample-buffer and display clock domains of the scope FPGA.

Parameters:
- N_DOMAINS, 4, number of downstream reset outputs (1..8).
- RST_HOLD, 16, cycles pll_reset is held high per attempt (≥2).
- LOCK_STABLE, 256, consecutive cycles synchronised lock must be high before release.
- LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK per attempt (> LOCK_STABLE).
- STAGGER, 8, cycles between successive domain reset releases (≥1).
- MAX_RETRIES, 3, failed attempts tolerated before FAIL (1..15).

Ports:
- refclk  in  1  free-running reference clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- extlock  in  1  raw PLL lock, asynchronous to refclk.
- sw_relock  in  1  single-cycle request to restart lock sequence.
- pll_reset  out  1  to PLL reset input, active-high.
- domain_rst  out  N_DOMAINS  per-domain synchronous resets, active-high.
- locked  out  1  all domains released and lock stable.
- fail  out  1  retries exhausted.
- retry_cnt  out  4  failed attempts since last RUN or sw_relock.
- loss_cnt  out  8  lock-loss events in RELEASE/RUN, saturates at 255.
- state  out  3  RESET_PLL=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAIL=4.

Behaviour:
- Clock and reset: one clock, refclk. reset is synchronous and active-high.
- Reset values: state=RESET_PLL, pll_reset=1, domain_rst=all 1, locked=0, fail=0, retry_cnt=0, loss_cnt=0, internal counters=0.
- extlock synchroniser: 2-flop, giving lock_s. Latency is 2 cycles and is included in all figures below. All outputs are registered.
- RESET_PLL:
  - pll_reset=1, domain_rst all 1.
  - After exactly RST_HOLD cycles in state → WAIT_LOCK; pll_reset=0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Stable counter increments while lock_s=1 and clears on any lock_s=0 cycle.
  - Timeout counter increments every cycle.
  - Stable counter reaches LOCK_STABLE → RELEASE.
  - Timeout counter reaches LOCK_TIMEOUT first → retry_cnt+1. Then FAIL if the new value equals MAX_RETRIES, else RESET_PLL.
  - Stable and timeout completing on the same cycle: stable wins.
- RELEASE:
  - domain_rst[0] deasserts in the first RELEASE cycle.
  - domain_rst[k] deasserts k*STAGGER cycles later. Release order is index 0 upward; a released domain stays released.
  - On the cycle domain_rst[N_DOMAINS-1] deasserts → RUN. locked=1 from the first RUN cycle.
- RUN: locked=1, domain_rst=0, retry_cnt cleared to 0 on entry.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - Next cycle all domain_rst=1, locked=0, loss_cnt+1 (saturating), → RESET_PLL.
  - Retry counting is unaffected.
- FAIL: pll_reset=1, domain_rst all 1, fail=1, locked=0. The block stays in FAIL until reset or sw_relock.
- sw_relock:
  - In any state, the next state is RESET_PLL, retry_cnt=0, fail=0, and all counters are cleared.
  - If RESET_PLL is already active, the RST_HOLD count restarts.
  - Simultaneous with lock loss: sw_relock wins and loss_cnt does not increment.
- reset overrides everything, including sw_relock on the same cycle.
- A short lock glitch (< LOCK_STABLE) in WAIT_LOCK only restarts the stable count. A glitch of ≥1 synchronised cycle in RUN is a loss.

Test Plan:
- extlock=1 throughout; reset released at cycle 0:
  - pll_reset falls at cycle 16.
  - domain_rst[0] falls at cycle 16+256, domain_rst[3] 24 cycles later.
  - locked=1 the next cycle; state=3, loss_cnt=0.
- extlock held 0, MAX_RETRIES=3:
  - Three RESET_PLL pulses of 16 cycles, each followed by a 4096-cycle wait.
  - Then state=4, fail=1, retry_cnt=3, pll_reset=1 held.
  - sw_relock pulse → state=0, fail=0, retry_cnt=0.
- In WAIT_LOCK, extlock high 200 cycles, low 3, then high: release occurs 256 cycles after the final rise (+2 sync), not earlier.
- In RUN, drop extlock for 1 cycle:
  - All domain_rst=1 and locked=0 three cycles after the drop; loss_cnt=1; state=0.
  - With extlock high again, the full sequence repeats to RUN.
- Force 300 lock losses: loss_cnt saturates at 255.
- Simultaneous events:
  - sw_relock on the same cycle as lock loss: loss_cnt unchanged.
  - sw_relock on the same cycle as reset: reset values result.
  - Stable and timeout completing on the same cycle (LOCK_TIMEOUT=LOCK_STABLE+2 variant): RELEASE entered, retry_cnt unchanged.
